// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family: index-width helper
// and the packet-lock state encoding.
package arb_pkg;

    localparam logic [0:0] ST_OPEN   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Width of a channel index; a single channel still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request strictly after ptr, with wrap.
// The request vector is doubled so the wrap becomes a plain low-to-high scan.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_masked;
    int             w_pos;
    logic           w_hit;

    assign w_dbl = {req, req};

    // Drop every lower-half position at or below the last grant.
    always_comb begin
        w_masked = '0;
        for (int j = 0; j < 2*N; j++) begin
            w_masked[j] = w_dbl[j] & (j > int'(ptr));
        end
    end

    // Lowest surviving position wins; fold the upper half back onto 0..N-1.
    always_comb begin
        w_pos = 0;
        w_hit = 1'b0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (w_masked[j]) begin
                w_pos = j;
                w_hit = 1'b1;
            end
        end
        any = w_hit;
        idx = IW'((w_pos >= N) ? (w_pos - N) : w_pos);
        gnt = w_hit ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/arbiter_rr_n.sv
// N-channel round-robin arbiter with a registered output slot and packet lock.
//
// state  | meaning
// -------+-------------------------------------------------------------
// OPEN   | round-robin search from ptr+1 picks the next channel
// LOCKED | mid-packet; only r_lock_ch may be granted until its last beat
module arbiter_rr_n
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 4,
    parameter int IW = idx_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    valid_in,
    input  logic [N*DW-1:0] data_in,
    input  logic [N-1:0]    last_in,
    output logic [N-1:0]    ready_out,
    output logic            valid_out,
    output logic [DW-1:0]   data_out,
    output logic            last_out,
    output logic [IW-1:0]   grant_id,
    input  logic            ready_in
);

    logic [0:0]    r_state;
    logic [IW-1:0] r_lock_ch;
    logic [IW-1:0] r_ptr;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_last;
    logic [IW-1:0] r_gid;

    logic          w_slot_free;
    logic [N-1:0]  w_pick_gnt;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic [IW-1:0] w_sel_idx;
    logic [N-1:0]  w_grant;
    logic          w_xfer;
    logic [DW-1:0] w_sel_data;
    logic          w_sel_last;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (valid_in),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Slot accepts a new beat when empty or when its beat leaves this cycle.
    assign w_slot_free = ~r_valid | ready_in;

    // Choose the candidate channel: the locked owner, or the round-robin pick.
    always_comb begin
        w_sel_idx = w_pick_idx;
        w_grant   = w_pick_any ? w_pick_gnt : '0;
        if (r_state == ST_LOCKED) begin
            w_sel_idx = r_lock_ch;
            w_grant   = valid_in & (N'(1) << r_lock_ch);
        end
    end

    assign ready_out = w_slot_free ? w_grant : '0;
    assign w_xfer    = |(valid_in & ready_out);

    // Data/last mux driven by the selected channel index.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == w_sel_idx) begin
                w_sel_data = data_in[i*DW +: DW];
                w_sel_last = last_in[i];
            end
        end
    end

    // Output slot: load on transfer, empty when the beat leaves with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_gid   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_sel_data;
            r_last  <= w_sel_last;
            r_gid   <= w_sel_idx;
        end else if (w_slot_free) begin
            r_valid <= 1'b0;
        end
    end

    // Round-robin pointer and packet-lock state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_OPEN;
            r_lock_ch <= '0;
            r_ptr     <= IW'(N-1);
        end else if (w_xfer) begin
            r_ptr <= w_sel_idx;
            case (r_state)
                ST_OPEN: begin
                    if (!w_sel_last) begin
                        r_state   <= ST_LOCKED;
                        r_lock_ch <= w_sel_idx;
                    end
                end
                ST_LOCKED: begin
                    if (w_sel_last) begin
                        r_state <= ST_OPEN;
                    end
                end
                default: r_state <= ST_OPEN;
            endcase
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign last_out  = r_last;
    assign grant_id  = r_gid;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Bench for arbiter_rr_n: a 4-channel instance driven from a vector table with
// a beat scoreboard, plus hand sequences for back-pressure and a 3-channel instance.
module tb_arbiter_rr_n;

    typedef struct {
        logic       rst;
        logic [3:0] vin;
        logic [3:0] lin;
        logic       rdy;
        logic [3:0] ro;
        logic [3:0] ro_mask;
        logic       vo;
    } vec_t;

    typedef struct {
        logic [1:0] gid;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, rdy4, vo4, lo4;
    logic [3:0]  vin4, lin4, ro4;
    logic [31:0] din4;
    logic [7:0]  dout4;
    logic [1:0]  gid4;

    logic        rst3, rdy3, vo3, lo3;
    logic [2:0]  vin3, lin3, ro3;
    logic [23:0] din3;
    logic [7:0]  dout3;
    logic [1:0]  gid3;

    arbiter_rr_n #(.N(4), .DW(8)) u4 (
        .clk(clk), .rst(rst4), .valid_in(vin4), .data_in(din4), .last_in(lin4),
        .ready_out(ro4), .valid_out(vo4), .data_out(dout4), .last_out(lo4),
        .grant_id(gid4), .ready_in(rdy4)
    );

    arbiter_rr_n #(.N(3), .DW(8)) u3 (
        .clk(clk), .rst(rst3), .valid_in(vin3), .data_in(din3), .last_in(lin3),
        .ready_out(ro3), .valid_out(vo3), .data_out(dout3), .last_out(lo3),
        .grant_id(gid3), .ready_in(rdy3)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    vec_t  tbl[$];
    beat_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] vin, input logic [3:0] lin,
                       input logic rdy, input logic [3:0] ro, input logic [3:0] mask,
                       input logic vo);
        vec_t v;
        v.rst = r; v.vin = vin; v.lin = lin; v.rdy = rdy;
        v.ro = ro; v.ro_mask = mask; v.vo = vo;
        tbl.push_back(v);
    endtask

    function automatic logic [7:0] data_of(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    initial begin
        logic  pend;
        beat_t b;
        beat_t nb;
        int    idx;

        rst4 = 1'b1; vin4 = '0; lin4 = '1; rdy4 = 1'b1;
        din4 = {8'h44, 8'h33, 8'h22, 8'h11};
        rst3 = 1'b1; vin3 = '0; lin3 = '1; rdy3 = 1'b1;
        din3 = {8'hC3, 8'hB2, 8'hA1};

        //  rst   vin      lin      rdy   ro       mask     vo
        add(1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b0);  // reset
        add(1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b1111, 1'b0);  // first grant ch0
        add(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b1111, 1'b1);
        add(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b1111, 1'b1);
        add(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b1111, 1'b1);
        add(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b1111, 1'b1);  // wrap to ch0
        add(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b1111, 1'b1);  // fairness 1,3,1,3
        add(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1000, 4'b1111, 1'b1);
        add(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b1111, 1'b1);
        add(1'b0, 4'b1010, 4'b1111, 1'b1, 4'b1000, 4'b1111, 1'b1);
        add(1'b0, 4'b0010, 4'b1111, 1'b1, 4'b0010, 4'b1111, 1'b1);  // ch1 alone, no bubble
        add(1'b0, 4'b0010, 4'b1111, 1'b1, 4'b0010, 4'b1111, 1'b1);
        add(1'b0, 4'b0010, 4'b1111, 1'b1, 4'b0010, 4'b1111, 1'b1);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b0);  // slot drained
        add(1'b0, 4'b1111, 4'b1011, 1'b1, 4'b0100, 4'b1111, 1'b0);  // ch2 packet beat 1
        add(1'b0, 4'b1111, 4'b1011, 1'b1, 4'b0100, 4'b1111, 1'b1);  // beat 2
        add(1'b0, 4'b1011, 4'b1011, 1'b1, 4'b0000, 4'b1011, 1'b1);  // ch2 drops, others stall
        add(1'b0, 4'b1011, 4'b1011, 1'b1, 4'b0000, 4'b1011, 1'b0);
        add(1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b1111, 1'b0);  // last beat
        add(1'b0, 4'b1011, 4'b1111, 1'b1, 4'b1000, 4'b1111, 1'b1);  // then ch3
        add(1'b0, 4'b1011, 4'b1111, 1'b1, 4'b0001, 4'b1111, 1'b1);  // then ch0
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b0);
        add(1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b1111, 1'b0);  // ch1 locks
        add(1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b1111, 1'b1);
        add(1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1);  // reset mid-packet
        add(1'b0, 4'b0011, 4'b1111, 1'b1, 4'b0001, 4'b1111, 1'b0);  // open again, ch0 first
        add(1'b0, 4'b0011, 4'b1111, 1'b1, 4'b0010, 4'b1111, 1'b1);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1);
        add(1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b0);

        pend = 1'b0;
        for (int k = 0; k < tbl.size(); k++) begin
            rst4 = tbl[k].rst;
            vin4 = tbl[k].vin;
            lin4 = tbl[k].lin;
            rdy4 = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("v%0d valid_out", k), 32'(vo4), 32'(tbl[k].vo));
            if (pend) begin
                b = sb.pop_front();
                chk($sformatf("v%0d grant_id", k), 32'(gid4), 32'(b.gid));
                chk($sformatf("v%0d data_out", k), 32'(dout4), 32'(b.data));
                chk($sformatf("v%0d last_out", k), 32'(lo4), 32'(b.last));
            end
            chk($sformatf("v%0d ready_out", k), 32'(ro4 & tbl[k].ro_mask),
                32'(tbl[k].ro & tbl[k].ro_mask));
            pend = 1'b0;
            if (!tbl[k].rst && |(tbl[k].vin & tbl[k].ro)) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (tbl[k].ro[i]) idx = i;
                nb.gid  = 2'(idx);
                nb.data = data_of(idx);
                nb.last = tbl[k].lin[idx];
                sb.push_back(nb);
                pend = 1'b1;
            end
            @(posedge clk); #1;
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        // Back-pressure: 0xA5 held in the slot for 5 stalled cycles.
        din4[7:0] = 8'hA5; vin4 = 4'b0001; lin4 = 4'b1111; rdy4 = 1'b1;
        @(negedge clk);
        chk("bp load ready_out", 32'(ro4), 32'h1);
        @(posedge clk); #1;
        rdy4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d valid_out", c), 32'(vo4), 32'h1);
            chk($sformatf("bp%0d data_out", c), 32'(dout4), 32'hA5);
            chk($sformatf("bp%0d grant_id", c), 32'(gid4), 32'h0);
            chk($sformatf("bp%0d ready_out", c), 32'(ro4), 32'h0);
            @(posedge clk); #1;
            din4[7:0] = 8'h5A;
        end
        rdy4 = 1'b1;
        @(negedge clk);
        chk("bp release ready_out", 32'(ro4), 32'h1);
        chk("bp release data_out", 32'(dout4), 32'hA5);
        @(posedge clk); #1;
        vin4 = 4'b0000;
        @(negedge clk);
        chk("bp next valid_out", 32'(vo4), 32'h1);
        chk("bp next data_out", 32'(dout4), 32'h5A);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp drain valid_out", 32'(vo4), 32'h0);
        @(posedge clk); #1;

        // Three channels: grant_id must cycle 0,1,2,0,... and never reach 3.
        rst3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst3 = 1'b0; vin3 = 3'b111; lin3 = 3'b111; rdy3 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("n3 c%0d ready_out", c), 32'(ro3), 32'(3'(1) << (c % 3)));
            chk($sformatf("n3 c%0d valid_out", c), 32'(vo3), (c == 0) ? 32'h0 : 32'h1);
            if (c > 0) begin
                chk($sformatf("n3 c%0d grant_id", c), 32'(gid3), 32'((c - 1) % 3));
                chk($sformatf("n3 c%0d data_out", c), 32'(dout3),
                    32'(8'hA1 + 8'h11 * ((c - 1) % 3)));
            end
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_n.md
# arbiter_rr_n

Parametrised N-channel round-robin arbiter with a registered output slot and packet lock. It merges N valid/ready input streams of DW-bit data onto one output stream and sits wherever several producers share one consumer link. Relative to the 4-channel arbiter, it:
- generalises channel count;
- adds synchronous reset;
- holds output data stable under back-pressure;
- keeps a grant locked to one channel until that channel's multi-beat packet ends.

## Interface
Parameters:
- N, 4, number of input channels (N ≥ 1, need not be a power of two)
- DW, 4, data width per channel
- IW, $clog2(N) (1 when N = 1), width of channel index

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- valid_in  input  N  per-channel request; bit i belongs to channel i
- data_in  input  N*DW  channel i data at [(i+1)*DW-1 : i*DW]
- last_in  input  N  per-channel end-of-packet flag, qualified by valid_in[i]
- ready_out  output  N  one-hot (or zero) grant/accept to channels
- valid_out  output  1  output slot holds a beat
- data_out  output  DW  beat data
- last_out  output  1  beat is end of packet
- grant_id  output  IW  channel index that produced the current beat
- ready_in  input  1  downstream consumer accepts the beat

## Operation
- Output slot:
  - free when valid_out == 0, or when valid_out & ready_in this cycle.
  - While the slot is not free, ready_out = 0 and data_out/last_out/grant_id hold.
- Channel selection when the slot is free:
  - Search valid_in starting at channel (ptr+1) mod N, upward with wrap; the first set bit wins.
  - ready_out = one-hot of the winner; zero if no request.
  - ptr is the last granted channel.
- Transfer:
  - Input i transfers when valid_in[i] & ready_out[i].
  - Next edge: data_out ← data_in[i], last_out ← last_in[i], grant_id ← i, valid_out ← 1, ptr ← i.
- No transfer while the slot is freeing: valid_out ← 0 at the edge.
- State machine:
  - OPEN: normal round-robin. A transfer with last_in = 0 moves to LOCKED(ch = i).
  - LOCKED: the search is bypassed and only ch may be granted, even if ch drops valid_in mid-packet. Other requesters stall.
  - A transfer from ch with last_in = 1 returns to OPEN.
- Single-beat packets (last_in = 1 on the first beat) never lock.
- ready_out depends combinationally on valid_in, ready_in and state. Upstream must not make valid_in depend on ready_out.
- Reset values: valid_out = 0, data_out = 0, last_out = 0, grant_id = 0, ptr = N-1 (channel 0 wins first), state OPEN.

## Timing
- Latency: one cycle from input handshake to valid_out.
- Throughput: one beat per cycle while ready_in is held high; no bubble between consecutive grants, including a channel switch.
- Back-pressure: with valid_out = 1 and ready_in = 0, all outputs are stable and ready_out = 0.
- Wrap-around: ptr = N-1 searches from channel 0. For non-power-of-two N, indices ≥ N are never produced.
- Simultaneous events: the output beat leaves and a new input beat enters in the same cycle; this is the normal streaming case.
- rst mid-packet: the lock is cleared and the slot is emptied on that edge. rst has priority over any handshake in the same cycle.
- N = 1: degenerates to a one-deep register slice with valid/ready handshake; grant_id = 0.

## Structure
- Shared package arb_pkg holds the clog2 helper used for IW and the OPEN/LOCKED state encoding (1 bit). Future arbiters in the family reuse both.
- One sub-module, rr_pick: purely combinational rotate-priority encoder.
  - Inputs: req[N], ptr[IW].
  - Outputs: one-hot gnt[N], idx[IW], any.
  - Implemented as a double-width request vector masked by ptr.
- Top level holds the output slot, ptr, lock state and the data mux.

## Test plan
- Reset and first grant: N=4, DW=8; assert rst for 2 cycles, then valid_in=4'b1111, all last_in=1, ready_in=1.
  - Outputs stay 0 during reset.
  - Afterwards grant_id sequence is 0,1,2,3,0, one beat per cycle, with data_out equal to each channel's data.
- Fairness and wrap: valid_in=4'b1010.
  - Grants alternate 1,3,1,3.
  - Dropping channel 3 then gives 1,1,1 with no bubble.
- Back-pressure: beat 0xA5 in the slot, ready_in=0 for 5 cycles.
  - data_out = 0xA5 and valid_out = 1 stable; ready_out = 4'b0000 throughout.
  - Release gives the next grant the same cycle.
- Packet lock: channel 2 sends a 3-beat packet (last on beat 3) while channels 0, 1 and 3 request; channel 2 drops valid_in for 2 cycles mid-packet.
  - Only ready_out[2] asserts until the last beat.
  - Then channel 3 is granted, then 0.
- Reset mid-packet: rst during a locked packet on channel 1.
  - The next cycle has valid_out = 0 and state OPEN.
  - The next grant is channel 0 when valid_in=4'b0011.
- Non-power-of-two: N=3, valid_in=3'b111.
  - grant_id cycles 0,1,2,0 and never shows 3.
